// File: rtl/stream_lane_merger_if.sv
// Stream bundle between the 2x32 splitter lanes, the merger and the
// merged 32-bit output.
//   s0_*  : lane 0 (low word) stream into the merger
//   s1_*  : lane 1 (high word) stream into the merger
//   m_*   : merged output stream with frame marker m_tlast
// Modport slave is the merger's view; master is the environment's view.
interface stream_lane_merger_if;
    localparam int unsigned DATA_W = 32;

    logic [DATA_W-1:0] s0_tdata;
    logic              s0_tvalid;
    logic              s0_tready;
    logic [DATA_W-1:0] s1_tdata;
    logic              s1_tvalid;
    logic              s1_tready;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tvalid;
    logic              m_tready;
    logic              m_tlast;

    modport slave (
        input  s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, m_tready,
        output s0_tready, s1_tready, m_tdata, m_tvalid, m_tlast
    );

    modport master (
        output s0_tdata, s0_tvalid, s1_tdata, s1_tvalid, m_tready,
        input  s0_tready, s1_tready, m_tdata, m_tvalid, m_tlast
    );
endinterface

// File: rtl/stream_lane_merger.sv
// Merges the two 32-bit lanes of the stream splitter back into one stream:
// each lane is buffered in a show-ahead FIFO and pairs are emitted as
// lane0 word then lane1 word, with m_tlast on the last word of each frame.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   bus            lane inputs s0_*/s1_* and merged output m_* (slave view)
//   err_clr        synchronous clear of the sticky skew error
//   frame_done     one-cycle pulse after a frame's last word is accepted
//   frame_count    completed frames, wraps at 2^16
//   lane_skew_err  sticky: lane fill levels differed by more than SKEW_MAX
module stream_lane_merger #(
    parameter int unsigned FRAME_SAMPLES = 3276,
    parameter int unsigned FIFO_DEPTH    = 16,
    parameter int unsigned SKEW_MAX      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    stream_lane_merger_if.slave   bus,
    input  logic                  err_clr,
    output logic                  frame_done,
    output logic [15:0]           frame_count,
    output logic                  lane_skew_err
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PAIR_W = $clog2(FRAME_SAMPLES);

    typedef enum logic {
        L0 = 1'b0,
        L1 = 1'b1
    } state_t;

    state_t            state;
    logic [PAIR_W-1:0] pair_cnt;

    logic [DATA_W-1:0] mem0 [FIFO_DEPTH];
    logic [DATA_W-1:0] mem1 [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr0, rd_ptr0, wr_ptr1, rd_ptr1;
    logic [CNT_W-1:0]  cnt0, cnt1;

    logic              push0, push1, pop0, pop1, accept, last_pair;
    logic [CNT_W-1:0]  skew;

    // Handshake and output muxing, all derived from registered state
    assign bus.s0_tready = (cnt0 != CNT_W'(FIFO_DEPTH));
    assign bus.s1_tready = (cnt1 != CNT_W'(FIFO_DEPTH));
    assign push0         = bus.s0_tvalid && bus.s0_tready;
    assign push1         = bus.s1_tvalid && bus.s1_tready;

    // L1 is only entered with lane 1 non-empty, so a started pair never waits
    assign bus.m_tvalid  = (state == L1) || ((cnt0 != '0) && (cnt1 != '0));
    assign bus.m_tdata   = (state == L1) ? mem1[rd_ptr1] : mem0[rd_ptr0];
    assign last_pair     = (pair_cnt == PAIR_W'(FRAME_SAMPLES - 1));
    assign bus.m_tlast   = (state == L1) && last_pair;

    assign accept        = bus.m_tvalid && bus.m_tready;
    assign pop0          = accept && (state == L0);
    assign pop1          = accept && (state == L1);

    assign skew          = (cnt0 >= cnt1) ? (cnt0 - cnt1) : (cnt1 - cnt0);

    // Lane 0 FIFO; storage is reset so the idle output head is never X
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr0 <= '0;
            rd_ptr0 <= '0;
            cnt0    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem0[PTR_W'(i)] <= '0;
            end
        end else begin
            if (push0) begin
                mem0[wr_ptr0] <= bus.s0_tdata;
                wr_ptr0       <= wr_ptr0 + PTR_W'(1);
            end
            if (pop0) begin
                rd_ptr0 <= rd_ptr0 + PTR_W'(1);
            end
            if (push0 && !pop0) begin
                cnt0 <= cnt0 + CNT_W'(1);
            end else if (pop0 && !push0) begin
                cnt0 <= cnt0 - CNT_W'(1);
            end
        end
    end

    // Lane 1 FIFO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr1 <= '0;
            rd_ptr1 <= '0;
            cnt1    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem1[PTR_W'(i)] <= '0;
            end
        end else begin
            if (push1) begin
                mem1[wr_ptr1] <= bus.s1_tdata;
                wr_ptr1       <= wr_ptr1 + PTR_W'(1);
            end
            if (pop1) begin
                rd_ptr1 <= rd_ptr1 + PTR_W'(1);
            end
            if (push1 && !pop1) begin
                cnt1 <= cnt1 + CNT_W'(1);
            end else if (pop1 && !push1) begin
                cnt1 <= cnt1 - CNT_W'(1);
            end
        end
    end

    // Output sequencer with pair/frame counting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= L0;
            pair_cnt    <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                L0: begin
                    if (accept) begin
                        state <= L1;
                    end
                end
                L1: begin
                    if (accept) begin
                        state <= L0;
                        if (last_pair) begin
                            pair_cnt    <= '0;
                            frame_count <= frame_count + 16'd1;
                            frame_done  <= 1'b1;
                        end else begin
                            pair_cnt <= pair_cnt + PAIR_W'(1);
                        end
                    end
                end
                default: state <= L0;
            endcase
        end
    end

    // Sticky skew error; a new violation wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_skew_err <= 1'b0;
        end else if (skew > CNT_W'(SKEW_MAX)) begin
            lane_skew_err <= 1'b1;
        end else if (err_clr) begin
            lane_skew_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_stream_lane_merger.sv
// Bench for stream_lane_merger: randomized lane/ready timing against a
// queue-based reference (expected output = lane words interleaved pairwise,
// m_tlast on every 2*FRAME_SAMPLES-th word since reset).
module tb_stream_lane_merger;
    localparam int unsigned FS  = 3276;
    localparam int unsigned WPF = 2 * FS;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        err_clr = 1'b0;
    logic        frame_done;
    logic [15:0] frame_count;
    logic        lane_skew_err;

    stream_lane_merger_if bus();

    stream_lane_merger #(
        .FRAME_SAMPLES (FS),
        .FIFO_DEPTH    (16),
        .SKEW_MAX      (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .err_clr       (err_clr),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .lane_skew_err (lane_skew_err)
    );

    always #5 clk = ~clk;

    int          n_cmp  = 0;
    int          n_fail = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] exp_d[$];
    logic [31:0] got_d[$];
    logic        got_l[$];

    int unsigned p0 = 100, p1 = 100, prdy = 100;
    logic        drv_clr = 1'b0;
    logic        hold0 = 1'b0, hold1 = 1'b0;
    int          n_push0 = 0, n_push1 = 0;
    int          done_cnt = 0, valid_cnt = 0, axi_viol = 0;
    int unsigned words_since_rst = 0, cap_base = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d = '0;
    logic        prev_l = 1'b0;

    // One clock: drive at negedge, observe 1ns later (handshakes then occur at the next posedge)
    task automatic cycle();
        @(negedge clk);
        bus.s0_tvalid = (q0.size() != 0) && (hold0 || ($urandom_range(99) < p0));
        bus.s0_tdata  = (q0.size() != 0) ? q0[0] : 32'h0;
        bus.s1_tvalid = (q1.size() != 0) && (hold1 || ($urandom_range(99) < p1));
        bus.s1_tdata  = (q1.size() != 0) ? q1[0] : 32'h0;
        bus.m_tready  = ($urandom_range(99) < prdy);
        err_clr       = drv_clr;
        #1;
        if (frame_done === 1'b1) done_cnt++;
        if (bus.m_tvalid === 1'b1) valid_cnt++;
        if (prev_stall && (bus.m_tvalid !== 1'b1 || bus.m_tdata !== prev_d || bus.m_tlast !== prev_l))
            axi_viol++;
        prev_stall = bus.m_tvalid && !bus.m_tready;
        prev_d     = bus.m_tdata;
        prev_l     = bus.m_tlast;
        if (bus.s0_tvalid && bus.s0_tready) begin
            void'(q0.pop_front());
            hold0 = 1'b0;
            n_push0++;
        end else begin
            hold0 = bus.s0_tvalid;
        end
        if (bus.s1_tvalid && bus.s1_tready) begin
            void'(q1.pop_front());
            hold1 = 1'b0;
            n_push1++;
        end else begin
            hold1 = bus.s1_tvalid;
        end
        if (bus.m_tvalid && bus.m_tready) begin
            got_d.push_back(bus.m_tdata);
            got_l.push_back(bus.m_tlast);
            words_since_rst++;
        end
    endtask

    task automatic run_words(input int n, input int budget);
        int c = 0;
        while (got_d.size() < n && c < budget) begin
            cycle();
            c++;
        end
    endtask

    task automatic clear_cap();
        got_d.delete();
        got_l.delete();
        exp_d.delete();
        cap_base  = words_since_rst;
        done_cnt  = 0;
        valid_cnt = 0;
        axi_viol  = 0;
        n_push0   = 0;
        n_push1   = 0;
    endtask

    task automatic send_pair(input logic [31:0] lo, input logic [31:0] hi);
        q0.push_back(lo);
        q1.push_back(hi);
        exp_d.push_back(lo);
        exp_d.push_back(hi);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        #2;
        rst_n         = 1'b0;
        bus.s0_tvalid = 1'b0;
        bus.s1_tvalid = 1'b0;
        bus.s0_tdata  = '0;
        bus.s1_tdata  = '0;
        bus.m_tready  = 1'b0;
        err_clr       = 1'b0;
        drv_clr       = 1'b0;
        q0.delete();
        q1.delete();
        hold0           = 1'b0;
        hold1           = 1'b0;
        prev_stall      = 1'b0;
        words_since_rst = 0;
        #1;
    endtask

    task automatic release_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic int first_seq_err();
        int n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
        for (int i = 0; i < n; i++) begin
            if (got_d[i] !== exp_d[i]) return i;
        end
        return -1;
    endfunction

    function automatic int first_last_err();
        for (int i = 0; i < got_l.size(); i++) begin
            logic e;
            e = (((cap_base + i) % WPF) == (WPF - 1));
            if (got_l[i] !== e) return i;
        end
        return -1;
    endfunction

    function automatic int count_last();
        int n = 0;
        for (int i = 0; i < got_l.size(); i++) begin
            if (got_l[i] === 1'b1) n++;
        end
        return n;
    endfunction

    task automatic test_reset();
        bus.s0_tvalid = 1'b0;
        bus.s1_tvalid = 1'b0;
        bus.s0_tdata  = '0;
        bus.s1_tdata  = '0;
        bus.m_tready  = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (bus.s0_tready !== 1'b1) begin n_fail++; $display("FAIL reset_s0_tready: got %b want 1", bus.s0_tready); end
        n_cmp++; if (bus.s1_tready !== 1'b1) begin n_fail++; $display("FAIL reset_s1_tready: got %b want 1", bus.s1_tready); end
        n_cmp++; if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b want 0", bus.m_tvalid); end
        n_cmp++; if (bus.m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast: got %b want 0", bus.m_tlast); end
        n_cmp++; if (bus.m_tdata !== 32'h0) begin n_fail++; $display("FAIL reset_m_tdata: got %h want 0", bus.m_tdata); end
        n_cmp++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
        n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL reset_frame_count: got %0d want 0", frame_count); end
        n_cmp++; if (lane_skew_err !== 1'b0) begin n_fail++; $display("FAIL reset_skew_err: got %b want 0", lane_skew_err); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_full_frame();
        int k;
        clear_cap();
        p0 = 100; p1 = 100; prdy = 100;
        for (int i = 0; i < int'(FS); i++) send_pair(32'(2 * i), 32'(2 * i + 1));
        run_words(int'(WPF), int'(WPF) + 200);
        repeat (4) cycle();
        n_cmp++; if (got_d.size() !== int'(WPF)) begin n_fail++; $display("FAIL full_count: got %0d words want %0d", got_d.size(), WPF); end
        k = first_seq_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL full_seq: word %0d got %h want %h", k, got_d[k], exp_d[k]); end
        n_cmp++; if (count_last() !== 1) begin n_fail++; $display("FAIL full_tlast_count: got %0d want 1", count_last()); end
        k = first_last_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL full_tlast_pos: word %0d has tlast %b", k, got_l[k]); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL full_frame_done: got %0d pulse cycles want 1", done_cnt); end
        n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL full_frame_count: got %0d want 1", frame_count); end
    endtask

    task automatic test_backpressure();
        int k;
        clear_cap();
        p0 = 100; p1 = 100; prdy = 100;
        for (int i = 0; i < 60; i++) send_pair($urandom, $urandom);
        repeat (10) cycle();
        prdy = 0;
        repeat (40) cycle();
        n_cmp++; if (bus.s0_tready !== 1'b0) begin n_fail++; $display("FAIL bp_s0_full: got tready %b want 0", bus.s0_tready); end
        n_cmp++; if (bus.s1_tready !== 1'b0) begin n_fail++; $display("FAIL bp_s1_full: got tready %b want 0", bus.s1_tready); end
        n_cmp++; if (bus.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL bp_m_tvalid: got %b want 1", bus.m_tvalid); end
        prdy = 100;
        run_words(120, 400);
        repeat (2) cycle();
        n_cmp++; if (got_d.size() !== 120) begin n_fail++; $display("FAIL bp_count: got %0d words want 120", got_d.size()); end
        k = first_seq_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL bp_seq: word %0d got %h want %h", k, got_d[k], exp_d[k]); end
        n_cmp++; if (axi_viol !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stall cycles want 0", axi_viol); end
        k = first_last_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL bp_tlast: word %0d has tlast %b", k, got_l[k]); end
    endtask

    task automatic test_skew();
        logic [31:0] lo [10];
        logic [31:0] hi [10];
        int          c = 0;
        int          k;
        clear_cap();
        p0 = 100; p1 = 100; prdy = 100;
        drv_clr = 1'b1; cycle(); drv_clr = 1'b0; cycle();
        n_cmp++; if (lane_skew_err !== 1'b0) begin n_fail++; $display("FAIL skew_pre_clear: got %b want 0", lane_skew_err); end
        for (int i = 0; i < 10; i++) begin
            lo[i] = $urandom;
            hi[i] = $urandom;
            q0.push_back(lo[i]);
            exp_d.push_back(lo[i]);
            exp_d.push_back(hi[i]);
        end
        while (n_push0 < 9 && c < 50) begin cycle(); c++; end
        cycle();
        n_cmp++; if (lane_skew_err !== 1'b0) begin n_fail++; $display("FAIL skew_at_9_buffered: got %b want 0", lane_skew_err); end
        cycle();
        n_cmp++; if (lane_skew_err !== 1'b1) begin n_fail++; $display("FAIL skew_set: got %b want 1", lane_skew_err); end
        repeat (4) cycle();
        n_cmp++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL skew_no_valid: got %0d valid cycles want 0", valid_cnt); end
        drv_clr = 1'b1; cycle(); drv_clr = 1'b0; cycle();
        n_cmp++; if (lane_skew_err !== 1'b1) begin n_fail++; $display("FAIL skew_set_wins: got %b want 1", lane_skew_err); end
        for (int i = 0; i < 10; i++) q1.push_back(hi[i]);
        run_words(20, 200);
        repeat (2) cycle();
        n_cmp++; if (got_d.size() !== 20) begin n_fail++; $display("FAIL skew_count: got %0d words want 20", got_d.size()); end
        k = first_seq_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL skew_seq: word %0d got %h want %h", k, got_d[k], exp_d[k]); end
        n_cmp++; if (lane_skew_err !== 1'b1) begin n_fail++; $display("FAIL skew_sticky: got %b want 1", lane_skew_err); end
        drv_clr = 1'b1; cycle(); drv_clr = 1'b0; cycle();
        n_cmp++; if (lane_skew_err !== 1'b0) begin n_fail++; $display("FAIL skew_clear: got %b want 0", lane_skew_err); end
    endtask

    task automatic test_l1_stall();
        logic [31:0] lo, hi;
        int          bad = 0;
        int          k;
        clear_cap();
        lo = $urandom;
        hi = ~lo;
        p0 = 100; p1 = 100; prdy = 100;
        send_pair(lo, hi);
        run_words(1, 50);
        prdy = 0;
        repeat (5) begin
            cycle();
            if (bus.m_tvalid !== 1'b1 || bus.m_tdata !== hi) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL l1_hold: %0d stall cycles without valid lane1 word %h (now valid %b data %h)", bad, hi, bus.m_tvalid, bus.m_tdata); end
        n_cmp++; if (got_d.size() !== 1) begin n_fail++; $display("FAIL l1_no_accept: got %0d words want 1", got_d.size()); end
        prdy = 100;
        run_words(2, 50);
        repeat (2) cycle();
        n_cmp++; if (got_d.size() !== 2) begin n_fail++; $display("FAIL l1_count: got %0d words want 2", got_d.size()); end
        k = first_seq_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL l1_seq: word %0d got %h want %h", k, got_d[k], exp_d[k]); end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_cap();
        p0 = 100; p1 = 100; prdy = 85;
        for (int i = 0; i < 200; i++) send_pair($urandom, $urandom);
        run_words(200, 1000);
        k = first_seq_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL mid_pre_seq: word %0d got %h want %h", k, got_d[k], exp_d[k]); end
        assert_reset();
        n_cmp++; if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL mid_async_valid: got %b want 0", bus.m_tvalid); end
        n_cmp++; if (bus.s0_tready !== 1'b1) begin n_fail++; $display("FAIL mid_async_tready: got %b want 1", bus.s0_tready); end
        n_cmp++; if (frame_count !== 16'd0) begin n_fail++; $display("FAIL mid_async_fcount: got %0d want 0", frame_count); end
        release_reset();
        clear_cap();
        p0 = 80; p1 = 80; prdy = 85;
        for (int i = 0; i < int'(FS); i++) send_pair($urandom, $urandom);
        run_words(int'(WPF), 20000);
        repeat (4) cycle();
        n_cmp++; if (got_d.size() !== int'(WPF)) begin n_fail++; $display("FAIL mid_count: got %0d words want %0d", got_d.size(), WPF); end
        k = first_seq_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL mid_seq: word %0d got %h want %h", k, got_d[k], exp_d[k]); end
        n_cmp++; if (count_last() !== 1) begin n_fail++; $display("FAIL mid_tlast_count: got %0d want 1", count_last()); end
        k = first_last_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL mid_tlast_pos: word %0d has tlast %b", k, got_l[k]); end
        n_cmp++; if (frame_count !== 16'd1) begin n_fail++; $display("FAIL mid_frame_count: got %0d want 1", frame_count); end
        n_cmp++; if (done_cnt !== 1) begin n_fail++; $display("FAIL mid_frame_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_back_to_back();
        int k;
        assert_reset();
        release_reset();
        clear_cap();
        p0 = 80; p1 = 80; prdy = 85;
        for (int i = 0; i < int'(FS); i++) send_pair($urandom, $urandom);
        run_words(int'(WPF), 20000);
        repeat (2) cycle();
        valid_cnt = 0;
        repeat (1172) cycle();
        n_cmp++; if (valid_cnt !== 0) begin n_fail++; $display("FAIL b2b_gap_valid: got %0d valid cycles want 0", valid_cnt); end
        for (int i = 0; i < int'(FS); i++) send_pair($urandom, $urandom);
        run_words(2 * int'(WPF), 20000);
        repeat (4) cycle();
        n_cmp++; if (got_d.size() !== 2 * int'(WPF)) begin n_fail++; $display("FAIL b2b_count: got %0d words want %0d", got_d.size(), 2 * WPF); end
        k = first_seq_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL b2b_seq: word %0d got %h want %h", k, got_d[k], exp_d[k]); end
        n_cmp++; if (count_last() !== 2) begin n_fail++; $display("FAIL b2b_tlast_count: got %0d want 2", count_last()); end
        k = first_last_err();
        n_cmp++; if (k !== -1) begin n_fail++; $display("FAIL b2b_tlast_pos: word %0d has tlast %b", k, got_l[k]); end
        n_cmp++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_frame_done: got %0d want 2", done_cnt); end
        n_cmp++; if (frame_count !== 16'd2) begin n_fail++; $display("FAIL b2b_frame_count: got %0d want 2", frame_count); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_skew();
        test_l1_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_lane_merger.md
Name: stream_lane_merger

Overview:
- Downstream stage of the 64-to-2x32 stream splitter. Consumes its two 32-bit lanes: lane 0 carries the low word, lane 1 the high word.
- Buffers each lane in its own small FIFO and re-serialises them as a single 32-bit AXI-Stream in the order lane0 word, lane1 word for each sample pair.
- Asserts tlast on the final word of every frame and reports frame progress and lane-skew errors to the control/status path.

Parameters:
- FRAME_SAMPLES, 3276: sample pairs per frame. Output frame = 2*FRAME_SAMPLES words.
- FIFO_DEPTH, 16: entries per lane FIFO. Power of two, >= 4.
- SKEW_MAX, 8: maximum allowed fill-level difference between lanes before an error is flagged.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s0_tdata  in  32  lane 0 data (low word)
- s0_tvalid  in  1  lane 0 valid
- s0_tready  out  1  lane 0 ready
- s1_tdata  in  32  lane 1 data (high word)
- s1_tvalid  in  1  lane 1 valid
- s1_tready  out  1  lane 1 ready
- m_tdata  out  32  merged output data
- m_tvalid  out  1  merged output valid
- m_tready  in  1  merged output ready
- m_tlast  out  1  last word of frame
- err_clr  in  1  synchronous clear of sticky error
- frame_done  out  1  one-cycle pulse when a frame's last word is accepted
- frame_count  out  16  completed frames, wraps at 2^16
- lane_skew_err  out  1  sticky lane skew error

Behaviour:
- Reset is asynchronous (rst_n low): both FIFOs empty, state L0, pair counter 0, frame_count 0. All outputs 0 except s0_tready=s1_tready=1. A reset asserted mid-frame discards all buffered data; the first pair after reset starts a new frame.
- Lane FIFOs are show-ahead, with registered storage and counts 0..FIFO_DEPTH.
  - sN_tready = !fullN, computed from the count at the start of the cycle.
  - A push occurs on sN_tvalid && sN_tready.
  - A push and a pop in the same cycle leave the count unchanged. A push never occurs when full; a pop never occurs when empty.
- Input latency: a word accepted at edge N can appear on m_tdata in the cycle after edge N, which is the minimum one-cycle latency.
- Output FSM has two states, L0 and L1:
  - L0: m_tvalid = (count0>0 && count1>0), m_tdata = fifo0 head. On m_tvalid && m_tready: pop fifo0, go to L1.
  - L1: m_tvalid = 1 (fifo1 is guaranteed non-empty because both FIFOs were checked on entry), m_tdata = fifo1 head. On accept: pop fifo1, increment the pair counter, go to L0.
  - A pair is never split by waiting on lane 1 after lane 0 has been emitted.
- AXI rules on the output:
  - m_tdata and m_tlast are stable while m_tvalid && !m_tready.
  - m_tvalid never drops without acceptance.
  - When m_tvalid is 0, m_tdata is don't-care but is driven from the FIFO head, not X.
- Framing:
  - m_tlast = 1 only in L1 when the pair counter == FRAME_SAMPLES-1.
  - On acceptance of that word: pair counter -> 0, frame_count += 1 (wraps 0xFFFF->0), and frame_done pulses for one cycle in the following cycle (registered).
- Skew detection:
  - Each cycle, compute diff = |count0-count1| from the registered counts.
  - If diff > SKEW_MAX, lane_skew_err is set at the next edge.
  - The error is sticky until err_clr is sampled high. If set and clear occur in the same cycle, set wins.
  - Data flow is never stalled by the error.
- Width rules: the pair counter is $clog2(FRAME_SAMPLES) bits and FIFO pointers are $clog2(FIFO_DEPTH) bits. Both wrap naturally; counts are one bit wider.
- Idle gaps between bursts need no special handling: the FSM waits in L0 with m_tvalid=0.

Test Plan:
- Both lanes each driven with 3276 words (lane0 = 2i, lane1 = 2i+1) and m_tready tied 1 -> output sequence 0,1,2,...,6551; m_tlast only on word 6551; frame_done pulses once; frame_count = 1.
- m_tready held 0 for 40 cycles mid-frame -> s0_tready and s1_tready drop once 16 entries are buffered; m_tdata stays stable; no words lost or duplicated after release.
- Lane 0 sends 10 words before lane 1 sends any (SKEW_MAX=8) -> lane_skew_err set after the 9th lane-0 word is buffered; m_tvalid stays 0; once lane 1 catches up, output order is still 0,1,2,... Pulse err_clr -> lane_skew_err = 0.
- Stall in L1 (lane-0 word accepted, m_tready=0 for 5 cycles) -> m_tdata holds the lane-1 word with m_tvalid=1; the FSM does not return to L0.
- rst_n asserted asynchronously after 100 pairs, then 3276 fresh pairs sent -> first output word after reset is the new lane-0 word; m_tlast falls on the 6552nd post-reset word; frame_count = 1.
- Run 2 back-to-back frames with a 1172-cycle idle gap between them -> frame_count = 2; exactly two m_tlast and two frame_done pulses; no spurious m_tvalid during the gap.
